// File: rtl/sdram_read_arbiter_if.sv
// sdram_read_arbiter_if: audio/video read ports, Avalon bridge port and grant/status of the read arbiter
interface sdram_read_arbiter_if;
   logic        aud_rden;
   logic [24:0] aud_addr;
   logic [15:0] aud_rddata;
   logic        aud_ack;
   logic        vid_rden;
   logic [24:0] vid_addr;
   logic [15:0] vid_rddata;
   logic        vid_ack;
   logic [24:0] mem_addr;
   logic        mem_read;
   logic [15:0] mem_rddata;
   logic        mem_ack;
   logic        gnt_aud;
   logic        gnt_vid;
   logic        err_timeout;
   modport slave (
      input  aud_rden, aud_addr, vid_rden, vid_addr, mem_rddata, mem_ack,
      output aud_rddata, aud_ack, vid_rddata, vid_ack, mem_addr, mem_read, gnt_aud, gnt_vid, err_timeout
   );
   modport master (
      output aud_rden, aud_addr, vid_rden, vid_addr, mem_rddata, mem_ack,
      input  aud_rddata, aud_ack, vid_rddata, vid_ack, mem_addr, mem_read, gnt_aud, gnt_vid, err_timeout
   );
endinterface

// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter: audio-priority read arbiter with bounded audio runs and ack timeout in front of an Avalon SDRAM bridge
module sdram_read_arbiter #(
   parameter int AUD_RUN_MAX = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input logic clk50,
   input logic reset,
   sdram_read_arbiter_if.slave bus
);
   localparam int RW = ($clog2(AUD_RUN_MAX + 1) > 3) ? $clog2(AUD_RUN_MAX + 1) : 3;
   localparam int TW = ($clog2(ACK_TIMEOUT + 1) > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   typedef enum logic [2:0] {IDLE, AUD_XFER, AUD_REL, VID_XFER, VID_REL} state_t;
   state_t state, state_n;
   logic [RW-1:0] run_cnt;
   logic [TW-1:0] tcnt;
   logic xfer, done, tout, run_full, grant_aud, grant_vid;
   always_ff @(posedge clk50 or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   // An ack on the timeout edge wins, so tout only fires without mem_ack.
   always_comb begin
      xfer = state == AUD_XFER || state == VID_XFER;
      done = xfer && bus.mem_ack;
      tout = xfer && !bus.mem_ack && tcnt == TW'(ACK_TIMEOUT - 1);
      run_full = run_cnt == RW'(AUD_RUN_MAX);
      grant_aud = state == IDLE && bus.aud_rden && !(bus.vid_rden && run_full);
      grant_vid = state == IDLE && bus.vid_rden && !grant_aud;
      state_n = state;
      case (state)
         IDLE:             state_n = grant_aud ? AUD_XFER : grant_vid ? VID_XFER : IDLE;
         AUD_XFER:         state_n = (done || tout) ? AUD_REL : AUD_XFER;
         VID_XFER:         state_n = (done || tout) ? VID_REL : VID_XFER;
         AUD_REL, VID_REL: state_n = bus.mem_ack ? state : IDLE;
         default:          state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk50 or posedge reset)
      if (reset) begin
         bus.mem_addr    <= '0;
         bus.mem_read    <= 1'b0;
         bus.aud_ack     <= 1'b0;
         bus.vid_ack     <= 1'b0;
         bus.aud_rddata  <= '0;
         bus.vid_rddata  <= '0;
         bus.gnt_aud     <= 1'b0;
         bus.gnt_vid     <= 1'b0;
         bus.err_timeout <= 1'b0;
         run_cnt         <= '0;
         tcnt            <= '0;
      end else begin
         bus.aud_ack <= done && state == AUD_XFER;
         bus.vid_ack <= done && state == VID_XFER;
         if (done && state == AUD_XFER) bus.aud_rddata <= bus.mem_rddata;
         if (done && state == VID_XFER) bus.vid_rddata <= bus.mem_rddata;
         if (grant_aud || grant_vid) begin
            bus.mem_addr <= grant_aud ? bus.aud_addr : bus.vid_addr;
            bus.mem_read <= 1'b1;
            tcnt         <= '0;
         end else if (done || tout) bus.mem_read <= 1'b0;
         else if (xfer) tcnt <= tcnt + TW'(1);
         if (tout) bus.err_timeout <= 1'b1;
         if (grant_vid) run_cnt <= '0;
         else if (grant_aud && bus.vid_rden && !run_full) run_cnt <= run_cnt + RW'(1);
         bus.gnt_aud <= state_n == AUD_XFER || state_n == AUD_REL;
         bus.gnt_vid <= state_n == VID_XFER || state_n == VID_REL;
      end
endmodule

// File: doc/sdram_read_arbiter.md
SDRAM_READ_ARBITER -- requirements
Module: sdram_read_arbiter

Interface
REQ-001 Parameter AUD_RUN_MAX, default 4: max consecutive audio grants while video is pending.
REQ-002 Parameter ACK_TIMEOUT, default 255: max cycles in a transfer state without mem_ack.
REQ-003 clk50  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 aud_rden  input  1  audio read request; level, held until aud_ack.
REQ-006 aud_addr  input  25  audio word address (16-bit words).
REQ-007 aud_rddata  output  16  audio read data.
REQ-008 aud_ack  output  1  audio completion pulse.
REQ-009 vid_rden  input  1  video read request; level, held until vid_ack.
REQ-010 vid_addr  input  25  video word address.
REQ-011 vid_rddata  output  16  video read data.
REQ-012 vid_ack  output  1  video completion pulse.
REQ-013 mem_addr  output  25  address to Avalon bridge.
REQ-014 mem_read  output  1  read strobe to Avalon bridge.
REQ-015 mem_rddata  input  16  bridge read data, valid while mem_ack is high.
REQ-016 mem_ack  input  1  bridge acknowledge; may stay high several cycles.
REQ-017 gnt_aud, gnt_vid  output  1 each  current owner, one-hot or both low.
REQ-018 err_timeout  output  1  sticky timeout flag.

Function
REQ-019 States SHALL be IDLE, AUD_XFER, AUD_REL, VID_XFER and VID_REL; all outputs SHALL be registered.
REQ-020 IDLE with aud_rden=1 and vid_rden=0 -> AUD_XFER; vid_rden=1 and aud_rden=0 -> VID_XFER; neither -> stay.
REQ-021 IDLE with both requests -> AUD_XFER, unless run_cnt==AUD_RUN_MAX, then VID_XFER.
REQ-022 run_cnt (3+ bits) SHALL increment on each audio grant made while vid_rden=1, clear on every video grant, and saturate at AUD_RUN_MAX.
REQ-023 On the grant edge, mem_addr SHALL latch the winner's address and mem_read SHALL go 1; later address changes are ignored until the next grant.
REQ-024 In XFER, the first cycle with mem_ack=1 SHALL produce the following at the next edge: mem_read=0, winner rddata=mem_rddata, winner ack=1 for exactly one cycle, state -> matching REL.
REQ-025 Latency: from the request seen in IDLE to mem_read=1 is 1 cycle; from mem_ack=1 to ack pulse is 1 cycle.
REQ-026 REL SHALL wait for mem_ack=0 and then go to IDLE, so there is one transfer per grant and no new grant while the bridge still acknowledges.
REQ-027 rddata registers SHALL hold their value until the next completed transfer for that requester; the other requester's register SHALL be unaffected.
REQ-028 gnt_aud SHALL be 1 in AUD_XFER and AUD_REL; gnt_vid SHALL be 1 in VID_XFER and VID_REL; both SHALL be 0 in IDLE.
REQ-029 mem_ack while in IDLE SHALL be ignored and produce no ack.
REQ-030 If a requester drops rden mid-transfer, the transfer SHALL complete and the ack pulse SHALL still issue.
REQ-031 A timeout counter SHALL clear on entry to XFER; when it reaches ACK_TIMEOUT: mem_read=0, err_timeout=1 (sticky), state -> REL, and no ack or data update occurs; the requester retries by holding rden.
REQ-032 mem_ack arriving on the same edge as the timeout SHALL count as success, with no error.
REQ-033 A requester still holding rden after its ack SHALL be re-arbitrated from IDLE as a new request.

Reset
REQ-034 Asserting reset at any time, including mid-transfer, SHALL force state IDLE, mem_read=0, mem_addr=0, aud_ack=vid_ack=0, gnt_aud=gnt_vid=0, rddata=0, run_cnt=0, timeout count=0 and err_timeout=0, without waiting for a clock edge.
REQ-035 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge of clk50.

Verification
REQ-036 aud_rden=1, aud_addr=0x00002C; bridge acks 3 cycles later with 0xBEEF -> mem_addr=0x00002C, mem_read high 4 cycles, aud_rddata=0xBEEF, one-cycle aud_ack, gnt_vid never high.
REQ-037 Both requesting continuously, AUD_RUN_MAX=4 -> grant order A,A,A,A,V,A,A,A,A,V; run_cnt clears after each V.
REQ-038 mem_ack held high 5 cycles -> single ack pulse; next grant only after mem_ack falls; vid_rddata unchanged after an audio transfer.
REQ-039 Bridge never acks, ACK_TIMEOUT=255 -> mem_read drops at cycle 255, err_timeout=1 and stays, no aud_ack, audio retried once IDLE is re-entered.
REQ-040 Reset pulsed while in VID_XFER with mem_read=1 -> all outputs 0 immediately; a stray mem_ack after reset causes no ack.
REQ-041 Stray mem_ack=1 in IDLE, then aud_rden dropped after grant -> no ack for the stray ack; the audio transfer completes and aud_ack issues.
